// File: rtl/bp_pht_update_sched.sv
// bp_pht_update_sched: PHT write-port sequencer (init sweep, retire-update FIFO drain, perf counters)
module bp_pht_update_sched #(
  parameter int PHT_DEPTH = 7,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd_valid,
  input  logic [PHT_DEPTH-1:0] upd_index,
  input  logic                 upd_taken,
  input  logic                 upd_mispred,
  input  logic                 clear_req,
  input  logic                 port_busy,
  input  logic [1:0]           pht_rdata,
  output logic                 pht_we,
  output logic [PHT_DEPTH-1:0] pht_widx,
  output logic [1:0]           pht_wdata,
  output logic                 bp_ready,
  output logic [7:0]           drop_cnt,
  output logic [15:0]          mispred_cnt
);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic [PHT_DEPTH-1:0] sweepPtr;
  logic [PHT_DEPTH-1:0] qIdx [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] qTaken;
  logic [QW:0] wrPtr, rdPtr;
  logic empty, full, deq, enq, drop, sweepWe, headTaken;
  logic [PHT_DEPTH-1:0] headIdx;
  logic [1:0] nextCtr;
  // FIFO status, arbitration and combinational write-port drive; rst gates writes immediately
  always_comb begin
    empty = wrPtr == rdPtr;
    full = (wrPtr[QW] != rdPtr[QW]) && (wrPtr[QW-1:0] == rdPtr[QW-1:0]);
    headIdx = qIdx[rdPtr[QW-1:0]];
    headTaken = qTaken[rdPtr[QW-1:0]];
    sweepWe = !rst && state == INIT && !port_busy;
    deq = !rst && state == RUN && !empty && !port_busy && !clear_req;
    enq = upd_valid && state == RUN && !clear_req && (!full || deq);
    drop = upd_valid && !enq;
    nextCtr = headTaken ? (pht_rdata == 2'b11 ? 2'b11 : pht_rdata + 2'b01)
                        : (pht_rdata == 2'b00 ? 2'b00 : pht_rdata - 2'b01);
    pht_we = sweepWe || deq;
    pht_widx = state == INIT ? sweepPtr : headIdx;
    pht_wdata = state == INIT ? INIT_STATE : nextCtr;
  end
  // init sweep pointer and INIT/RUN sequencing; clear_req restarts the sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      sweepPtr <= '0;
      bp_ready <= 1'b0;
    end else if (clear_req) begin
      state <= INIT;
      sweepPtr <= '0;
      bp_ready <= 1'b0;
    end else if (sweepWe) begin
      sweepPtr <= sweepPtr + 1'b1;
      if (&sweepPtr) begin
        state <= RUN;
        bp_ready <= 1'b1;
      end
    end
  end
  // FIFO pointers with wrap bit; clear_req flushes without counting drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (clear_req) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (enq) wrPtr <= wrPtr + 1'b1;
      if (deq) rdPtr <= rdPtr + 1'b1;
    end
  end
  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (enq) begin
      qIdx[wrPtr[QW-1:0]] <= upd_index;
      qTaken[wrPtr[QW-1:0]] <= upd_taken;
    end
  end
  // saturating drop counter and wrapping mispredict counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
      mispred_cnt <= '0;
    end else begin
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      if (enq && upd_mispred) mispred_cnt <= mispred_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_bp_pht_update_sched.sv
// tb_bp_pht_update_sched: directed checks of sweep, update drain, overflow, clear and async reset
module tb_bp_pht_update_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic upd_valid = 1'b0, upd_taken = 1'b0, upd_mispred = 1'b0, clear_req = 1'b0, port_busy = 1'b0;
  logic [6:0] upd_index = '0;
  logic [1:0] pht_rdata;
  logic pht_we, bp_ready;
  logic [6:0] pht_widx;
  logic [1:0] pht_wdata;
  logic [7:0] drop_cnt;
  logic [15:0] mispred_cnt;
  logic [1:0] pht [128];
  int checks = 0;
  int errors = 0;
  int writes, errs, cycles;
  bp_pht_update_sched dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .clear_req(clear_req), .port_busy(port_busy), .pht_rdata(pht_rdata),
    .pht_we(pht_we), .pht_widx(pht_widx), .pht_wdata(pht_wdata), .bp_ready(bp_ready),
    .drop_cnt(drop_cnt), .mispred_cnt(mispred_cnt)
  );
  always #5 clk = ~clk;
  // PHT array model behind the write port
  assign pht_rdata = pht[pht_widx];
  always @(posedge clk) if (pht_we) pht[pht_widx] <= pht_wdata;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [6:0] idx, input logic t, input logic m,
                       input logic busy, input logic clr);
    upd_valid = v; upd_index = idx; upd_taken = t; upd_mispred = m; port_busy = busy; clear_req = clr;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic doSweep(input bit toggle, input int pulses, output int w, output int e, output int c);
    int expIdx = 0;
    int p = 0;
    w = 0; e = 0; c = 0;
    while (!bp_ready && c < 1000) begin
      drive((p < pulses) && (c % 3 == 0), 7'd3, 1'b1, 1'b1, toggle && (c % 2 == 1), 1'b0);
      if (upd_valid) p++;
      if (pht_we == port_busy) e++;
      if (pht_we) begin
        if (pht_widx != 7'(expIdx) || pht_wdata != 2'b01) e++;
        expIdx++;
        w++;
      end
      tick();
      c++;
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    #1;
    check("rst_we", pht_we, 0);
    check("rst_ready", bp_ready, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_misp", mispred_cnt, 0);
    @(posedge clk);
    tick();
    rst = 1'b0;
    doSweep(0, 0, writes, errs, cycles);
    check("sweep0_writes", writes, 128);
    check("sweep0_cycles", cycles, 128);
    check("sweep0_errs", errs, 0);
    check("sweep0_idle_we", pht_we, 0);
    drive(1, 5, 1, 0, 0, 0);
    check("t3_first_we", pht_we, 0);
    tick();
    drive(1, 5, 1, 1, 0, 0);
    check("t3_w1_we", pht_we, 1);
    check("t3_w1_idx", pht_widx, 5);
    check("t3_w1_data", pht_wdata, 2'b10);
    tick();
    drive(1, 5, 1, 0, 0, 0);
    check("t3_w2_data", pht_wdata, 2'b11);
    tick();
    drive(1, 5, 0, 0, 0, 0);
    check("t3_w3_data", pht_wdata, 2'b11);
    tick();
    drive(1, 9, 0, 0, 0, 0);
    check("t3_nt_idx", pht_widx, 5);
    check("t3_nt_data", pht_wdata, 2'b10);
    tick();
    drive(1, 9, 0, 0, 0, 0);
    check("t3_dec9_idx", pht_widx, 9);
    check("t3_dec9_data", pht_wdata, 2'b00);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("t3_sat0_data", pht_wdata, 2'b00);
    check("t3_sat0_we", pht_we, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("t3_idle_we", pht_we, 0);
    check("t3_misp", mispred_cnt, 1);
    check("t3_drop", drop_cnt, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 7'(10 + i), (i % 2 == 0), 1, 1, 0);
      tick();
    end
    check("t4_drop", drop_cnt, 2);
    check("t4_misp", mispred_cnt, 5);
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 0, 0, 0, 0);
      check("t4_drain_we", pht_we, 1);
      check("t4_drain_idx", pht_widx, 32'(10 + j));
      check("t4_drain_data", pht_wdata, (j % 2 == 0) ? 2'b10 : 2'b00);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("t4_empty_we", pht_we, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 7'(20 + i), 1, 0, 1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 1);
    check("t5_clr_we", pht_we, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("t5_ready", bp_ready, 0);
    check("t5_drop", drop_cnt, 2);
    check("t5_idx0", pht_widx, 0);
    doSweep(1, 5, writes, errs, cycles);
    check("sweep1_writes", writes, 128);
    check("sweep1_cycles", cycles, 255);
    check("sweep1_errs", errs, 0);
    check("sweep1_drop", drop_cnt, 7);
    check("sweep1_misp", mispred_cnt, 5);
    check("t5_flushed_we", pht_we, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 7'(30 + i), 0, 1, 1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("t6_drain_we", pht_we, 1);
    check("t6_drain_idx", pht_widx, 30);
    check("t6_misp", mispred_cnt, 8);
    #2;
    rst = 1'b1;
    #1;
    check("t6_arst_we", pht_we, 0);
    check("t6_arst_ready", bp_ready, 0);
    check("t6_arst_drop", drop_cnt, 0);
    check("t6_arst_misp", mispred_cnt, 0);
    tick();
    rst = 1'b0;
    doSweep(0, 0, writes, errs, cycles);
    check("sweep2_writes", writes, 128);
    check("sweep2_cycles", cycles, 128);
    check("sweep2_errs", errs, 0);
    check("sweep2_idle_we", pht_we, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
